// File: rtl/math24_async_engine_if.sv
// Purpose: bundles the math engine's CSR-side signals (operand/control CSR
//          reads in, secondary w2 write port out) into one connection.
// Ports:   iw_math_ctrl/opa/opb/opc (CSR file -> engine), ow_csr_wen/waddr/wdata (engine -> CSR file).
// CSR indices are 12 bits wide; the engine owns the MATH_* index constants.
interface math24_async_engine_if;
    logic [23:0] iw_math_ctrl;
    logic [23:0] iw_math_opa;
    logic [23:0] iw_math_opb;
    logic [23:0] iw_math_opc;
    logic        ow_csr_wen;
    logic [11:0] ow_csr_waddr;
    logic [23:0] ow_csr_wdata;

    // CSR-file side: presents CSR contents, absorbs w2 writes.
    modport master (
        output iw_math_ctrl, iw_math_opa, iw_math_opb, iw_math_opc,
        input  ow_csr_wen, ow_csr_waddr, ow_csr_wdata
    );

    // Engine side.
    modport slave (
        input  iw_math_ctrl, iw_math_opa, iw_math_opb, iw_math_opc,
        output ow_csr_wen, ow_csr_waddr, ow_csr_wdata
    );
endinterface

// File: rtl/math24_async_engine.sv
// Purpose: 24-bit background math coprocessor (mul/div/sqrt/min/max/abs/clamp) fed from CSRs.
// Latency: start -> ACK write -> BUSY status -> CALC (1, 12 or 24 cycles) -> RES0, RES1, STATUS writes.
// Backpressure: none on w2 (one write per cycle); a start seen while busy waits in the CSR until IDLE.
// Ports: iw_clk, iw_rst (async, active-low), bus (slave modport of math24_async_engine_if).
module math24_async_engine (
    input  logic                        iw_clk,
    input  logic                        iw_rst,
    math24_async_engine_if.slave        bus
);
    localparam logic [11:0] IDX_CTRL   = 12'h7C0;
    localparam logic [11:0] IDX_STATUS = 12'h7C1;
    localparam logic [11:0] IDX_RES0   = 12'h7C5;
    localparam logic [11:0] IDX_RES1   = 12'h7C6;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACK    = 3'd1;
    localparam logic [2:0] S_BUSYST = 3'd2;
    localparam logic [2:0] S_CALC   = 3'd3;
    localparam logic [2:0] S_WR0    = 3'd4;
    localparam logic [2:0] S_WR1    = 3'd5;
    localparam logic [2:0] S_WRST   = 3'd6;

    localparam logic [3:0] OP_MULU    = 4'h0;
    localparam logic [3:0] OP_DIVU    = 4'h1;
    localparam logic [3:0] OP_MULS    = 4'h2;
    localparam logic [3:0] OP_SQRTU   = 4'h3;
    localparam logic [3:0] OP_DIVS    = 4'h5;
    localparam logic [3:0] OP_ABS_S   = 4'h7;
    localparam logic [3:0] OP_MIN_U   = 4'h8;
    localparam logic [3:0] OP_MAX_U   = 4'h9;
    localparam logic [3:0] OP_MIN_S   = 4'hA;
    localparam logic [3:0] OP_MAX_S   = 4'hB;
    localparam logic [3:0] OP_CLAMP_U = 4'hC;
    localparam logic [3:0] OP_CLAMP_S = 4'hD;

    logic [2:0]  state;
    logic [3:0]  op;
    logic [23:0] opa, opb, opc;
    logic [23:0] res1;
    logic        div0;
    logic [4:0]  cnt;
    logic [23:0] div_q, div_r, div_d;
    logic [23:0] sq_x;
    logic [11:0] sq_root;
    logic [13:0] sq_rem;
    logic        wen;
    logic [11:0] waddr;
    logic [23:0] wdata;

    // Signed divide runs on magnitudes; signs are reapplied to the final quotient/remainder.
    logic        a_neg, b_neg, q_neg;
    logic [23:0] a_mag, b_mag;
    assign a_neg = (op == OP_DIVS) && opa[23];
    assign b_neg = (op == OP_DIVS) && opb[23];
    assign q_neg = a_neg ^ b_neg;
    assign a_mag = a_neg ? -opa : opa;
    assign b_mag = b_neg ? -opb : opb;

    // Restoring divide step: shift in next dividend bit, subtract divisor if it fits.
    logic [24:0] div_sh;
    logic        div_ge;
    logic [23:0] div_diff, div_r_nxt, div_q_nxt;
    assign div_sh    = {div_r, div_q[23]};
    assign div_ge    = div_sh >= {1'b0, div_d};
    assign div_diff  = div_sh[23:0] - div_d;   // exact whenever div_ge, result < divisor
    assign div_r_nxt = div_ge ? div_diff : div_sh[23:0];
    assign div_q_nxt = {div_q[22:0], div_ge};

    // Digit-by-digit square root: two radicand bits in, one root bit out per step.
    logic [15:0] sq_sh, sq_trial;
    logic        sq_ge;
    logic [13:0] sq_rem_nxt;
    logic [11:0] sq_root_nxt;
    assign sq_sh       = {sq_rem, sq_x[23:22]};
    assign sq_trial    = {2'b00, sq_root, 2'b01};
    assign sq_ge       = sq_sh >= sq_trial;
    assign sq_rem_nxt  = 14'(sq_ge ? (sq_sh - sq_trial) : sq_sh);
    assign sq_root_nxt = {sq_root[10:0], sq_ge};

    // Single-cycle datapath.
    logic [47:0] prod_u, prod_s;
    logic        lt_u, lt_s;
    logic [23:0] lo_u, lo_s, cl_u, cl_s;
    assign prod_u = {24'd0, opa} * {24'd0, opb};
    // Low 48 bits of the product of sign-extended operands is the signed product.
    assign prod_s = {{24{opa[23]}}, opa} * {{24{opb[23]}}, opb};
    assign lt_u   = opa < opb;
    assign lt_s   = $signed(opa) < $signed(opb);
    assign lo_u   = (opa < opc) ? opc : opa;
    assign cl_u   = (lo_u > opb) ? opb : lo_u;
    assign lo_s   = ($signed(opa) < $signed(opc)) ? opc : opa;
    assign cl_s   = ($signed(lo_s) > $signed(opb)) ? opb : lo_s;

    logic [23:0] calc_r0, calc_r1;
    logic        calc_div0, calc_done;
    always_comb begin
        calc_r0   = '0;
        calc_r1   = '0;
        calc_div0 = 1'b0;
        calc_done = 1'b1;
        case (op)
            OP_MULU: begin calc_r0 = prod_u[23:0]; calc_r1 = prod_u[47:24]; end
            OP_MULS: begin calc_r0 = prod_s[23:0]; calc_r1 = prod_s[47:24]; end
            OP_DIVU, OP_DIVS: begin
                if (opb == 24'd0) begin
                    calc_r0   = 24'hFFFFFF;
                    calc_r1   = opa;
                    calc_div0 = 1'b1;
                end else begin
                    calc_done = (cnt == 5'd23);
                    calc_r0   = q_neg ? -div_q_nxt : div_q_nxt;
                    calc_r1   = a_neg ? -div_r_nxt : div_r_nxt;
                end
            end
            OP_SQRTU: begin
                calc_done = (cnt == 5'd11);
                calc_r0   = {12'd0, sq_root_nxt};
                calc_r1   = {10'd0, sq_rem_nxt};
            end
            OP_ABS_S:   calc_r0 = opa[23] ? -opa : opa;
            OP_MIN_U:   calc_r0 = lt_u ? opa : opb;
            OP_MAX_U:   calc_r0 = lt_u ? opb : opa;
            OP_MIN_S:   calc_r0 = lt_s ? opa : opb;
            OP_MAX_S:   calc_r0 = lt_s ? opb : opa;
            OP_CLAMP_U: calc_r0 = cl_u;
            OP_CLAMP_S: calc_r0 = cl_s;
            default: ;
        endcase
    end

    // Write outputs are registered on entry to each write state, so they are
    // valid exactly while the FSM sits in that state.
    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            state <= S_IDLE;  op <= '0;  opa <= '0;  opb <= '0;  opc <= '0;
            res1 <= '0;  div0 <= 1'b0;  cnt <= '0;
            div_q <= '0;  div_r <= '0;  div_d <= '0;
            sq_x <= '0;  sq_root <= '0;  sq_rem <= '0;
            wen <= 1'b0;  waddr <= '0;  wdata <= '0;
        end else begin
            wen <= 1'b0;
            case (state)
                S_IDLE: if (bus.iw_math_ctrl[0]) begin
                    op    <= bus.iw_math_ctrl[4:1];
                    opa   <= bus.iw_math_opa;
                    opb   <= bus.iw_math_opb;
                    opc   <= bus.iw_math_opc;
                    div0  <= 1'b0;
                    state <= S_ACK;
                    wen   <= 1'b1;
                    waddr <= IDX_CTRL;
                    wdata <= {bus.iw_math_ctrl[23:1], 1'b0};
                end
                S_ACK: begin
                    state <= S_BUSYST;
                    wen   <= 1'b1;
                    waddr <= IDX_STATUS;
                    wdata <= 24'h000002;
                end
                S_BUSYST: begin
                    state   <= S_CALC;
                    cnt     <= '0;
                    div_q   <= a_mag;
                    div_r   <= '0;
                    div_d   <= b_mag;
                    sq_x    <= opa;
                    sq_root <= '0;
                    sq_rem  <= '0;
                end
                S_CALC: begin
                    cnt     <= cnt + 5'd1;
                    div_q   <= div_q_nxt;
                    div_r   <= div_r_nxt;
                    sq_x    <= {sq_x[21:0], 2'b00};
                    sq_root <= sq_root_nxt;
                    sq_rem  <= sq_rem_nxt;
                    if (calc_done) begin
                        state <= S_WR0;
                        res1  <= calc_r1;
                        div0  <= calc_div0;
                        wen   <= 1'b1;
                        waddr <= IDX_RES0;
                        wdata <= calc_r0;
                    end
                end
                S_WR0: begin
                    state <= S_WR1;
                    wen   <= 1'b1;
                    waddr <= IDX_RES1;
                    wdata <= res1;
                end
                S_WR1: begin
                    state <= S_WRST;
                    wen   <= 1'b1;
                    waddr <= IDX_STATUS;
                    wdata <= {21'd0, div0, 1'b0, 1'b1};
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ow_csr_wen   = wen;
    assign bus.ow_csr_waddr = waddr;
    assign bus.ow_csr_wdata = wdata;
endmodule

// File: tb/tb_math24_async_engine.sv
// Purpose: self-checking bench for math24_async_engine; acts as the CSR file and checks every w2 write.
// Latency: each op is followed until its ready STATUS write, bounded by a cycle budget.
// Backpressure: none; the bench stores CTRL writes back so the self-clearing start is modelled.
module tb_math24_async_engine;
    localparam logic [11:0] IDX_CTRL   = 12'h7C0;
    localparam logic [11:0] IDX_STATUS = 12'h7C1;
    localparam logic [11:0] IDX_RES0   = 12'h7C5;
    localparam logic [11:0] IDX_RES1   = 12'h7C6;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [11:0] log_a[$];
    logic [23:0] log_d[$];
    int          log_c[$];
    logic [23:0] cur_ctrl;

    math24_async_engine_if bus();

    math24_async_engine dut (
        .iw_clk (clk),
        .iw_rst (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [23:0] v);
        return v[23] ? longint'(v) - 64'sd16777216 : longint'(v);
    endfunction

    // Reference model: straight arithmetic on integers.
    task automatic model(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] c, output logic [23:0] r0, output logic [23:0] r1,
                         output logic d0, output int clen);
        longint ua, ub, uc, sa, sb, sc, t;
        logic [47:0] p;
        ua = longint'(a); ub = longint'(b); uc = longint'(c);
        sa = sx(a); sb = sx(b); sc = sx(c);
        r0 = '0; r1 = '0; d0 = 1'b0; clen = 1;
        case (op)
            4'h0: begin p = 48'(ua * ub); r0 = p[23:0]; r1 = p[47:24]; end
            4'h2: begin p = 48'(sa * sb); r0 = p[23:0]; r1 = p[47:24]; end
            4'h1, 4'h5: begin
                if (b == 24'd0) begin
                    r0 = 24'hFFFFFF; r1 = a; d0 = 1'b1;
                end else begin
                    clen = 24;
                    if (op == 4'h1) begin r0 = 24'(ua / ub); r1 = 24'(ua % ub); end
                    else            begin r0 = 24'(sa / sb); r1 = 24'(sa % sb); end
                end
            end
            4'h3: begin
                t = 0;
                while ((t + 1) * (t + 1) <= ua) t++;
                r0 = 24'(t); r1 = 24'(ua - t * t); clen = 12;
            end
            4'h7: r0 = 24'((sa < 0) ? -sa : sa);
            4'h8: r0 = (ua < ub) ? a : b;
            4'h9: r0 = (ua > ub) ? a : b;
            4'hA: r0 = (sa < sb) ? a : b;
            4'hB: r0 = (sa > sb) ? a : b;
            4'hC: begin t = (ua < uc) ? uc : ua; t = (t > ub) ? ub : t; r0 = 24'(t); end
            4'hD: begin t = (sa < sc) ? sc : sa; t = (t > sb) ? sb : t; r0 = 24'(t); end
            default: ;
        endcase
    endtask

    // One clock: sample at the falling edge, log writes, reflect CTRL writes back into the CSR.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.ow_csr_wen) begin
            log_a.push_back(bus.ow_csr_waddr);
            log_d.push_back(bus.ow_csr_wdata);
            log_c.push_back(cyc);
            if (bus.ow_csr_waddr == IDX_CTRL) bus.iw_math_ctrl = bus.ow_csr_wdata;
        end
    endtask

    task automatic clear_log();
        log_a.delete(); log_d.delete(); log_c.delete();
    endtask

    task automatic launch(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                          input logic [23:0] c, input logic [18:0] hi);
        bus.iw_math_opa  = a;
        bus.iw_math_opb  = b;
        bus.iw_math_opc  = c;
        cur_ctrl         = {hi, op, 1'b1};
        bus.iw_math_ctrl = cur_ctrl;
        clear_log();
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            if (bus.ow_csr_wen && bus.ow_csr_waddr == IDX_STATUS && bus.ow_csr_wdata[0]) seen = 1'b1;
        end
        chk({tag, ":done"}, 48'(seen), 48'd1);
    endtask

    task automatic verify(input string tag, input logic [3:0] op, input logic [23:0] a,
                          input logic [23:0] b, input logic [23:0] c, input logic [23:0] ctrl);
        logic [23:0] r0, r1;
        logic        d0;
        int          clen;
        model(op, a, b, c, r0, r1, d0, clen);
        chk({tag, ":nwr"}, 48'(log_a.size()), 48'd5);
        if (log_a.size() == 5) begin
            chk({tag, ":ack"},  48'({log_a[0], log_d[0]}), 48'({IDX_CTRL, ctrl & 24'hFFFFFE}));
            chk({tag, ":busy"}, 48'({log_a[1], log_d[1]}), 48'({IDX_STATUS, 24'h000002}));
            chk({tag, ":res0"}, 48'({log_a[2], log_d[2]}), 48'({IDX_RES0, r0}));
            chk({tag, ":res1"}, 48'({log_a[3], log_d[3]}), 48'({IDX_RES1, r1}));
            chk({tag, ":stat"}, 48'({log_a[4], log_d[4]}), 48'({IDX_STATUS, 21'd0, d0, 2'b01}));
            chk({tag, ":clen"}, 48'(log_c[2] - log_c[1] - 1), 48'(clen));
            chk({tag, ":gap"},  48'(log_c[4] - log_c[2]), 48'd2);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [23:0] a,
                       input logic [23:0] b, input logic [23:0] c);
        launch(op, a, b, c, 19'd0);
        wait_done(tag);
        verify(tag, op, a, b, c, cur_ctrl);
    endtask

    initial begin
        logic [23:0] ctrl1, ctrl2;
        rst_n = 1'b0;
        bus.iw_math_ctrl = '0; bus.iw_math_opa = '0; bus.iw_math_opb = '0; bus.iw_math_opc = '0;
        step(); step();
        chk("reset_out", 48'({bus.ow_csr_wen, bus.ow_csr_waddr, bus.ow_csr_wdata}), 48'd0);
        rst_n = 1'b1;
        step();
        chk("idle_quiet", 48'(bus.ow_csr_wen), 48'd0);

        // Directed cases.
        run("mulu",     4'h0, 24'h00FF00, 24'h000010, 24'h0);
        run("muls",     4'h2, 24'hFFFFFE, 24'h000003, 24'h0);
        run("divu",     4'h1, 24'd100, 24'd7, 24'h0);
        run("divs",     4'h5, 24'hFFFF9C, 24'd7, 24'h0);
        run("divs_min", 4'h5, 24'h800000, 24'hFFFFFF, 24'h0);
        run("div0",     4'h1, 24'd123, 24'd0, 24'h0);
        run("after0",   4'h0, 24'd3, 24'd5, 24'h0);
        run("minu",     4'h8, 24'd5, 24'd9, 24'h0);
        run("maxs",     4'hB, 24'hFFFFFB, 24'd3, 24'h0);
        run("abs",      4'h7, 24'hFFFFF9, 24'h0, 24'h0);
        run("abs_min",  4'h7, 24'h800000, 24'h0, 24'h0);
        run("clampu",   4'hC, 24'd30, 24'd20, 24'd10);
        run("clamps",   4'hD, 24'hFFFFF6, 24'd15, 24'hFFFFFB);
        run("clamp_cb", 4'hC, 24'd5, 24'd10, 24'd40);
        run("sqrt",     4'h3, 24'd20736, 24'h0, 24'h0);
        run("sqrt_max", 4'h3, 24'hFFFFFF, 24'h0, 24'h0);
        run("rsvd",     4'hE, 24'd77, 24'd88, 24'd99);

        // Start re-asserted (with new operands) while a divide is still iterating.
        launch(4'h1, 24'd100, 24'd7, 24'd0, 19'h2A5A5);
        ctrl1 = cur_ctrl;
        for (int i = 0; i < 20 && log_a.size() < 2; i++) step();
        step(); step(); step();
        bus.iw_math_opa  = 24'h001234;
        bus.iw_math_opb  = 24'h000010;
        ctrl2            = {19'd0, 4'h0, 1'b1};
        bus.iw_math_ctrl = ctrl2;
        wait_done("rearm_div");
        verify("rearm_div", 4'h1, 24'd100, 24'd7, 24'd0, ctrl1);
        clear_log();
        wait_done("rearm_mul");
        verify("rearm_mul", 4'h0, 24'h001234, 24'h000010, 24'd0, ctrl2);

        // Reset in the middle of a divide: nothing further is written.
        launch(4'h1, 24'd1000000, 24'd3, 24'd0, 19'd0);
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_out", 48'({bus.ow_csr_wen, bus.ow_csr_waddr, bus.ow_csr_wdata}), 48'd0);
        step(); step();
        rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 40; i++) step();
        chk("midrst_quiet", 48'(log_a.size()), 48'd0);
        run("post_rst", 4'h0, 24'd1000, 24'd1000, 24'd0);

        // Randomized ops against the model.
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [23:0] a, b, c;
            logic [18:0] hi;
            op = 4'($urandom_range(0, 15));
            a  = 24'($urandom);
            c  = 24'($urandom);
            hi = 19'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 24'd0;
                1:       b = 24'($urandom_range(1, 255));
                default: b = 24'($urandom);
            endcase
            launch(op, a, b, c, hi);
            wait_done($sformatf("rnd%0d", n));
            verify($sformatf("rnd%0d_op%0h", n, op), op, a, b, c, cur_ctrl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
